// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared ALU select codes and sequencer state encoding
package alu_seq_pkg;
    localparam logic [2:0] OP_ADD2  = 3'b000;
    localparam logic [2:0] OP_SUB2  = 3'b001;
    localparam logic [2:0] OP_ADD1  = 3'b010;
    localparam logic [2:0] OP_SUB1  = 3'b011;
    localparam logic [2:0] OP_ADDSM = 3'b100;
    localparam logic [2:0] OP_SUBSM = 3'b101;
    localparam logic [2:0] OP_AND   = 3'b110;
    localparam logic [2:0] OP_OR    = 3'b111;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/alu_ovf_detect.sv
// alu_ovf_detect: combinational per-format overflow flag for the 8-bit multi-format ALU
module alu_ovf_detect
    import alu_seq_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [7:0] i_r,
    input  logic [2:0] i_sel,
    output logic       o_ovf
);
    logic       w_bs;
    logic [7:0] w_mag;
    // 2's/1's formats use sign rules; sign-magnitude overflows only when like signs carry out of the magnitude
    always_comb begin
        w_bs  = (i_sel == OP_SUBSM) ? ~i_b[7] : i_b[7];
        w_mag = {1'b0, i_a[6:0]} + {1'b0, i_b[6:0]};
        o_ovf = (i_sel == OP_ADD2 || i_sel == OP_ADD1)   ? (i_a[7] == i_b[7] && i_r[7] != i_a[7]) :
                (i_sel == OP_SUB2 || i_sel == OP_SUB1)   ? (i_a[7] != i_b[7] && i_r[7] != i_a[7]) :
                (i_sel == OP_ADDSM || i_sel == OP_SUBSM) ? (i_a[7] == w_bs && w_mag[7]) : 1'b0;
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: handshake-driven command/response sequencer for the combinational ALU; ALU_SEQ_OVF_FLAG_EN enables rsp_ovf
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_opa,
    input  logic [WIDTH-1:0] cmd_opb,
    output logic [WIDTH-1:0] alu_opa,
    output logic [WIDTH-1:0] alu_opb,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic [2:0]       rsp_sel,
    output logic             rsp_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 1");
    end
    if (WIDTH != 8) begin : g_bad_width
        $error("only WIDTH=8 is supported");
    end
    state_t           r_state;
    logic [SW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_alu_opa;
    logic [WIDTH-1:0] r_alu_opb;
    logic [2:0]       r_alu_sel;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_res;
    logic [2:0]       r_rsp_sel;
    logic             r_rsp_ovf;
    logic             r_cmd_ready;
    logic             r_busy;
    logic [CNT_W-1:0] r_op_count;
    logic             w_ovf;
`ifdef ALU_SEQ_OVF_FLAG_EN
    alu_ovf_detect u_ovf (
        .i_a   (r_alu_opa),
        .i_b   (r_alu_opb),
        .i_r   (alu_res),
        .i_sel (r_alu_sel),
        .o_ovf (w_ovf)
    );
`else
    assign w_ovf = 1'b0;
`endif
    // IDLE -> WAIT on accept, WAIT counts down the settle interval then captures, RESP holds until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_alu_opa   <= '0;
            r_alu_opb   <= '0;
            r_alu_sel   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_res   <= '0;
            r_rsp_sel   <= '0;
            r_rsp_ovf   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                IDLE: if (cmd_valid) begin
                    r_alu_opa   <= cmd_opa;
                    r_alu_opb   <= cmd_opb;
                    r_alu_sel   <= cmd_sel;
                    r_cnt       <= SW'(SETTLE_CYCLES - 1);
                    r_cmd_ready <= 1'b0;
                    r_busy      <= 1'b1;
                    r_state     <= WAIT;
                end
                WAIT: if (r_cnt == '0) begin
                    r_rsp_res   <= alu_res;
                    r_rsp_sel   <= r_alu_sel;
                    r_rsp_ovf   <= w_ovf;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                RESP: if (rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_op_count  <= r_op_count + 1'b1;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign alu_opa   = r_alu_opa;
    assign alu_opb   = r_alu_opb;
    assign alu_sel   = r_alu_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_res   = r_rsp_res;
    assign rsp_sel   = r_rsp_sel;
    assign rsp_ovf   = r_rsp_ovf;
    assign op_count  = r_op_count;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed checks of handshake, latency, capture, overflow, backpressure, reset and counter wrap
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;
`ifdef ALU_SEQ_OVF_FLAG_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;

    logic       c0_valid = 1'b0, k0_ready, a0_sel_dummy;
    logic [2:0] c0_sel = '0, a0_sel, r0_sel;
    logic [7:0] c0_opa = '0, c0_opb = '0, a0_opa, a0_opb, a0_res = '0, r0_res;
    logic       r0_valid, r0_ready = 1'b1, r0_ovf, b0_busy;
    logic [3:0] n0_count;

    logic       c3_valid = 1'b0, k3_ready;
    logic [2:0] c3_sel = '0, a3_sel, r3_sel;
    logic [7:0] c3_opa = '0, c3_opb = '0, a3_opa, a3_opb, a3_res = '0, r3_res;
    logic       r3_valid, r3_ready = 1'b0, r3_ovf, b3_busy;
    logic [15:0] n3_count;

    assign a0_sel_dummy = 1'b0;

    alu_cmd_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1), .CNT_W(4)) u0 (
        .clk(clk), .rst(rst), .cmd_valid(c0_valid), .cmd_ready(k0_ready), .cmd_sel(c0_sel),
        .cmd_opa(c0_opa), .cmd_opb(c0_opb), .alu_opa(a0_opa), .alu_opb(a0_opb), .alu_sel(a0_sel),
        .alu_res(a0_res), .rsp_valid(r0_valid), .rsp_ready(r0_ready), .rsp_res(r0_res),
        .rsp_sel(r0_sel), .rsp_ovf(r0_ovf), .busy(b0_busy), .op_count(n0_count)
    );

    alu_cmd_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_ready(k3_ready), .cmd_sel(c3_sel),
        .cmd_opa(c3_opa), .cmd_opb(c3_opb), .alu_opa(a3_opa), .alu_opb(a3_opb), .alu_sel(a3_sel),
        .alu_res(a3_res), .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_res(r3_res),
        .rsp_sel(r3_sel), .rsp_ovf(r3_ovf), .busy(b3_busy), .op_count(n3_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op0(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic ovf);
        c0_valid = 1'b1; c0_sel = s; c0_opa = a; c0_opb = b; a0_res = r;
        step();
        c0_valid = 1'b0;
        check("u0_alu_opa", a0_opa, a);
        check("u0_alu_opb", a0_opb, b);
        check("u0_alu_sel", a0_sel, s);
        check("u0_wait_valid", r0_valid, 0);
        check("u0_wait_cmd_ready", k0_ready, 0);
        step();
        check("u0_rsp_valid", r0_valid, 1);
        check("u0_rsp_res", r0_res, r);
        check("u0_rsp_sel", r0_sel, s);
        check("u0_rsp_ovf", r0_ovf, ovf);
        check("u0_rsp_busy", b0_busy, 1);
    endtask

    task automatic done0(input logic [3:0] cnt);
        r0_ready = 1'b1;
        step();
        check("u0_done_valid", r0_valid, 0);
        check("u0_done_cmd_ready", k0_ready, 1);
        check("u0_done_busy", b0_busy, 0);
        check("u0_op_count", n0_count, cnt);
    endtask

    task automatic reset_state3(input string tag);
        check({tag, "_valid"}, r3_valid, 0);
        check({tag, "_cmd_ready"}, k3_ready, 1);
        check({tag, "_busy"}, b3_busy, 0);
        check({tag, "_count"}, n3_count, 0);
        check({tag, "_alu_opa"}, a3_opa, 0);
        check({tag, "_alu_sel"}, a3_sel, 0);
        check({tag, "_rsp_res"}, r3_res, 0);
        check({tag, "_rsp_sel"}, r3_sel, 0);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_cmd_ready", k0_ready, 1);
        check("rst_busy", b0_busy, 0);
        check("rst_rsp_valid", r0_valid, 0);
        check("rst_op_count", n0_count, 0);
        check("rst_alu_opa", a0_opa, 0);
        check("rst_rsp_res", r0_res, 0);
        check("rst_rsp_ovf", r0_ovf, 0);
        // basic 2's add, then signed overflow, then mixed formats
        op0(OP_ADD2, 8'hFD, 8'hFC, 8'hF9, 1'b0);  done0(4'd1);
        op0(OP_ADD2, 8'h7F, 8'h01, 8'h80, OVF);   done0(4'd2);
        op0(OP_ADD1, 8'hFC, 8'hFB, 8'hF8, 1'b0);  done0(4'd3);
        op0(OP_ADDSM, 8'h83, 8'h84, 8'h87, 1'b0); done0(4'd4);
        op0(OP_ADDSM, 8'h7F, 8'h01, 8'h00, OVF);  done0(4'd5);
        op0(OP_SUBSM, 8'h40, 8'hC0, 8'h00, OVF);  done0(4'd6);
        op0(OP_AND, 8'hFF, 8'hFF, 8'hFF, 1'b0);   done0(4'd7);
        // backpressure with an ignored command presented during RESP
        r0_ready = 1'b0;
        op0(OP_SUB2, 8'h80, 8'h01, 8'h7F, OVF);
        c0_valid = 1'b1; c0_sel = OP_OR; c0_opa = 8'h0F; c0_opb = 8'hF0; a0_res = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", r0_valid, 1);
            check("bp_res", r0_res, 8'h7F);
            check("bp_sel", r0_sel, OP_SUB2);
            check("bp_cmd_ready", k0_ready, 0);
            check("bp_busy", b0_busy, 1);
            check("bp_alu_opa_held", a0_opa, 8'h80);
        end
        r0_ready = 1'b1;
        a0_res = 8'hFF;
        step();
        check("bp_release_valid", r0_valid, 0);
        check("bp_release_count", n0_count, 8);
        check("bp_release_cmd_ready", k0_ready, 1);
        check("bp_release_alu_opa", a0_opa, 8'h80);
        step();
        c0_valid = 1'b0;
        check("late_accept_alu_opa", a0_opa, 8'h0F);
        check("late_accept_alu_sel", a0_sel, OP_OR);
        check("late_accept_busy", b0_busy, 1);
        step();
        check("late_rsp_res", r0_res, 8'hFF);
        check("late_rsp_ovf", r0_ovf, 0);
        done0(4'd9);
        // counter wraps from 15 to 0
        for (int i = 10; i <= 16; i++) begin
            op0(OP_OR, 8'h01, 8'h02, 8'h03, 1'b0);
            done0(4'(i));
        end
        check("wrap_zero", n0_count, 0);
        // settle of 3: capture happens at the third edge after acceptance
        c3_valid = 1'b1; c3_sel = OP_OR; c3_opa = 8'h03; c3_opb = 8'h84; a3_res = 8'h55;
        step();
        c3_valid = 1'b0;
        check("s3_t1_valid", r3_valid, 0);
        check("s3_t1_busy", b3_busy, 1);
        a3_res = 8'h11;
        step();
        check("s3_t2_valid", r3_valid, 0);
        check("s3_t2_alu_opb", a3_opb, 8'h84);
        step();
        check("s3_t3_valid", r3_valid, 0);
        a3_res = 8'h87;
        step();
        check("s3_t4_valid", r3_valid, 1);
        check("s3_res", r3_res, 8'h87);
        check("s3_sel", r3_sel, OP_OR);
        check("s3_ovf", r3_ovf, 0);
        a3_res = 8'h00;
        step();
        check("s3_res_held", r3_res, 8'h87);
        // reset during RESP drops the response
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_state3("rst_resp");
        // reset during WAIT
        c3_valid = 1'b1; c3_sel = OP_ADD2; c3_opa = 8'h12; c3_opb = 8'h34; a3_res = 8'h46;
        step();
        c3_valid = 1'b0;
        check("rw_busy", b3_busy, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_state3("rst_wait");
        step();
        reset_state3("rst_idle_after");
        // a full transaction after reset counts once
        c3_valid = 1'b1; c3_sel = OP_SUB2; c3_opa = 8'h10; c3_opb = 8'h01; a3_res = 8'h0F;
        step();
        c3_valid = 1'b0;
        step(); step(); step();
        check("s3b_valid", r3_valid, 1);
        check("s3b_res", r3_res, 8'h0F);
        r3_ready = 1'b1;
        step();
        check("s3b_count", n3_count, 1);
        check("s3b_cmd_ready", k3_ready, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side driver for the 8-bit multi-format ALU (sel 000..111: 2's add/sub, 1's add/sub, sign-magnitude add/sub, AND, OR).
- Accepts one operation per valid/ready handshake and drives registered opA/opB/sel into the combinational ALU.
- Waits a programmable settle interval, which covers mapped/SDF-annotated ALU delay, then captures the result.
- Returns the result on a valid/ready response channel with an optional per-format overflow flag.

Parameters:
WIDTH, 8, operand/result width; only 8 is supported.
SETTLE_CYCLES, 1, clock cycles spent in WAIT before capture; must be >=1, elaboration error otherwise.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_sel  in  3  ALU operation code
cmd_opa  in  WIDTH  operand A
cmd_opb  in  WIDTH  operand B
alu_opa  out  WIDTH  registered operand A to ALU
alu_opb  out  WIDTH  registered operand B to ALU
alu_sel  out  3  registered select to ALU
alu_res  in  WIDTH  ALU combinational result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_res  out  WIDTH  captured result
rsp_sel  out  3  sel of the operation being reported
rsp_ovf  out  1  overflow flag (see Optional Feature)
busy  out  1  high in any state other than IDLE
op_count  out  CNT_W  completed responses; wraps to 0

Behaviour:
Reset values:
- All outputs 0 except cmd_ready=1; state IDLE.

IDLE:
- cmd_ready=1.
- On cmd_valid at an edge: alu_opa/alu_opb/alu_sel load cmd fields on that edge, settle counter loads SETTLE_CYCLES-1, go to WAIT.

WAIT:
- alu_* held stable.
- Counter decrements each cycle.
- On the edge where counter==0: rsp_res<=alu_res, rsp_sel<=alu_sel, rsp_ovf computed from alu_opa/alu_opb/alu_res, rsp_valid<=1, go to RESP.

RESP:
- rsp_* held stable while rsp_ready is low.
- On an edge with rsp_ready=1: rsp_valid<=0, op_count increments (mod 2^CNT_W), go to IDLE.

Latency and throughput:
- Command accepted at edge T gives rsp_valid=1 after edge T+SETTLE_CYCLES.
- Minimum issue interval is SETTLE_CYCLES+2 cycles.

Boundary conditions:
- No command/response overlap: cmd_ready=0 during WAIT and RESP, so a simultaneous rsp_ready and cmd_valid in RESP accepts the command only after returning to IDLE.
- alu_* keep their last values in IDLE; they are not cleared after an operation.
- cmd_* are ignored when cmd_ready=0.
- rst at any state, including mid-WAIT and mid-RESP, returns to IDLE with reset values. The pending response is dropped and op_count is not incremented.
- op_count wraps from all-ones to 0 silently.

Optional Feature:
Macro ALU_SEQ_OVF_FLAG_EN.
Defined: rsp_ovf is computed as follows (a=alu_opa, b=alu_opb, r=alu_res; bit 7 is sign).
- sel 000: a7==b7 && r7!=a7
- sel 001: a7!=b7 && r7!=a7
- sel 010: a7==b7 && r7!=a7
- sel 011: a7!=b7 && r7!=a7
- sel 100/101: effective sign of b is b7 for 100 and ~b7 for 101. When a7 equals the effective sign of b, ovf = (a[6:0]+b[6:0]) >127; otherwise ovf=0.
- sel 110/111: 0
Undefined: rsp_ovf tied 0; no overflow logic synthesized.

Decomposition:
- Package alu_seq_pkg holds:
  - sel localparams: OP_ADD2=000, OP_SUB2=001, OP_ADD1=010, OP_SUB1=011, OP_ADDSM=100, OP_SUBSM=101, OP_AND=110, OP_OR=111
  - state encoding: IDLE, WAIT, RESP
- One sub-module, alu_ovf_detect: purely combinational (a, b, r, sel -> ovf), instantiated only under ALU_SEQ_OVF_FLAG_EN.

Test Plan:
- sel=000, A=FD, B=FC, SETTLE_CYCLES=1, rsp_ready=1 -> rsp_valid 1 cycle after acceptance edge, rsp_res=F9, rsp_ovf=0, op_count=1.
- sel=000, A=7F, B=01 -> rsp_res=80; with macro rsp_ovf=1, without rsp_ovf=0.
- sel=010, A=FC, B=FB -> rsp_res=F8. Then sel=100, A=83, B=84 -> rsp_res=87, rsp_ovf=0. Then sel=100, A=7F, B=01 -> rsp_ovf=1 (macro on).
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_res/rsp_sel stable, cmd_ready=0, busy=1 throughout. rsp_ready=1 -> IDLE next cycle, op_count+1.
- SETTLE_CYCLES=3, sel=111, A=03, B=84 -> rsp_valid after edge T+3, rsp_res=87. Changing alu_res during WAIT before the final edge does not affect the captured value.
- rst asserted during WAIT, then during RESP -> next cycle all outputs at reset values, cmd_ready=1, op_count unchanged at 0.
